// File: rtl/driver_mc.sv
// driver_mc: multi-channel address FIFO / vector counter block behind a slave register port.
// Each channel owns a first-word-fall-through address FIFO, a vector-word level counter,
// a saturating vector total and a saturating drop counter. Sticky ovf/unf/drop flags feed irq.
module driver_mc #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_DEPTH = 16,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              slave_addr,
  input  logic                     slave_rd,
  input  logic                     slave_wr,
  input  logic [31:0]              slave_data_in,
  output logic [31:0]              slave_data_out,
  output logic [NUM_CH*DATA_W-1:0] addr_fifo_dout,
  output logic [NUM_CH-1:0]        addr_fifo_empty,
  input  logic [NUM_CH-1:0]        addr_fifo_rd,
  input  logic [NUM_CH-1:0]        vctr_fifo_wr,
  input  logic [NUM_CH-1:0]        vctr_fifo_rd,
  output logic                     irq
);

  localparam int               AW        = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;
  localparam logic [AW:0]      DEPTH     = (AW+1)'(ADDR_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [31:0]      CH_BASE   = 32'h100;
  localparam logic [31:0]      CH_STRIDE = 32'h20;

  // Byte address of a per-channel register.
  function automatic logic [31:0] reg_addr(input int ch, input logic [31:0] off);
    return CH_BASE + CH_STRIDE * 32'(ch) + off;
  endfunction

  // Saturating increment used by the total and drop counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [DATA_W-1:0] mem  [NUM_CH][ADDR_DEPTH];
  logic [AW-1:0]     wptr [NUM_CH];
  logic [AW-1:0]     rptr [NUM_CH];
  logic [AW:0]       alvl [NUM_CH];
  logic [CNT_W-1:0]  vlvl [NUM_CH];
  logic [CNT_W-1:0]  vtot [NUM_CH];
  logic [CNT_W-1:0]  dcnt [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, unf_q, drop_q;

  logic              soft_clr, st_wr;
  logic [NUM_CH-1:0] push, pop, push_ok, drop_ev, ovf_ev, unf_ev;
  logic [NUM_CH-1:0] w1c_ovf, w1c_unf, w1c_drop;
  logic [31:0]       rd_val;

  // Decode strobes into per-channel events (pop on empty and push on full are filtered here).
  always_comb begin
    soft_clr = slave_wr && (slave_addr == 32'h0) && slave_data_in[0];
    st_wr    = slave_wr && (slave_addr == 32'h4);
    w1c_ovf  = st_wr ? slave_data_in[NUM_CH-1:0]    : '0;
    w1c_unf  = st_wr ? slave_data_in[8 +: NUM_CH]   : '0;
    w1c_drop = st_wr ? slave_data_in[16 +: NUM_CH]  : '0;
    push    = '0;
    pop     = '0;
    push_ok = '0;
    drop_ev = '0;
    ovf_ev  = '0;
    unf_ev  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      push[i]    = slave_wr && (slave_addr == reg_addr(i, 32'h0));
      pop[i]     = addr_fifo_rd[i] && (alvl[i] != '0);
      push_ok[i] = push[i] && ((alvl[i] != DEPTH) || pop[i]);
      drop_ev[i] = push[i] && (alvl[i] == DEPTH) && !pop[i];
      ovf_ev[i]  = vctr_fifo_wr[i] && !vctr_fifo_rd[i] && (vlvl[i] == CNT_MAX);
      unf_ev[i]  = vctr_fifo_rd[i] && !vctr_fifo_wr[i] && (vlvl[i] == '0);
    end
  end

  // Register read mux over the pre-edge state; unmapped addresses read 0.
  always_comb begin
    rd_val = '0;
    if (slave_addr == 32'h4) begin
      rd_val[NUM_CH-1:0]  = ovf_q;
      rd_val[8 +: NUM_CH] = unf_q;
      rd_val[16 +: NUM_CH] = drop_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (slave_addr == reg_addr(i, 32'h04)) rd_val = 32'(alvl[i]);
      if (slave_addr == reg_addr(i, 32'h08)) rd_val = 32'(vlvl[i]);
      if (slave_addr == reg_addr(i, 32'h0C)) rd_val = 32'(vtot[i]);
      if (slave_addr == reg_addr(i, 32'h10)) rd_val = 32'(dcnt[i]);
    end
  end

  // FIFO head is shown straight from storage; forced to 0 while empty so it is stable.
  always_comb begin
    addr_fifo_dout  = '0;
    addr_fifo_empty = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      addr_fifo_empty[i] = (alvl[i] == '0);
      addr_fifo_dout[i*DATA_W +: DATA_W] = addr_fifo_empty[i] ? '0 : mem[i][rptr[i]];
    end
  end

  // FIFO storage write; pointers guard visibility so no reset is needed on the array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push_ok[i] && !soft_clr) mem[i][wptr[i]] <= slave_data_in[DATA_W-1:0];
    end
  end

  // Pointers, FIFO levels and the vector/total/drop counters; soft clear behaves like reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || soft_clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        alvl[i] <= '0;
        vlvl[i] <= '0;
        vtot[i] <= '0;
        dcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_ok[i]) wptr[i] <= wptr[i] + AW'(1);
        if (pop[i])     rptr[i] <= rptr[i] + AW'(1);
        if (push_ok[i] && !pop[i])      alvl[i] <= alvl[i] + (AW+1)'(1);
        else if (pop[i] && !push_ok[i]) alvl[i] <= alvl[i] - (AW+1)'(1);
        if (vctr_fifo_wr[i] && !vctr_fifo_rd[i] && !ovf_ev[i])      vlvl[i] <= vlvl[i] + CNT_W'(1);
        else if (vctr_fifo_rd[i] && !vctr_fifo_wr[i] && !unf_ev[i]) vlvl[i] <= vlvl[i] - CNT_W'(1);
        if (vctr_fifo_wr[i]) vtot[i] <= sat_inc(vtot[i]);
        if (drop_ev[i])      dcnt[i] <= sat_inc(dcnt[i]);
      end
    end
  end

  // Read data capture, sticky flags (set beats W1C) and the registered irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slave_data_out <= '0;
      ovf_q          <= '0;
      unf_q          <= '0;
      drop_q         <= '0;
      irq            <= 1'b0;
    end else begin
      if (slave_rd) slave_data_out <= rd_val;
      if (soft_clr) begin
        ovf_q  <= '0;
        unf_q  <= '0;
        drop_q <= '0;
        irq    <= 1'b0;
      end else begin
        ovf_q  <= (ovf_q  & ~w1c_ovf)  | ovf_ev;
        unf_q  <= (unf_q  & ~w1c_unf)  | unf_ev;
        drop_q <= (drop_q & ~w1c_drop) | drop_ev;
        irq    <= |{ovf_q, unf_q, drop_q};
      end
    end
  end

endmodule

// File: tb/tb_driver_mc.sv
// Bench for driver_mc: a vector table, hand sequences for the multi-cycle corners and a
// randomized phase, all compared against a queue/integer model of the register behaviour.
module tb_driver_mc;
  localparam int NCH   = 4;
  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int CMAX  = 65535;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       slave_addr, slave_data_in, slave_data_out;
  logic              slave_rd, slave_wr, irq;
  logic [NCH*DW-1:0] addr_fifo_dout;
  logic [NCH-1:0]    addr_fifo_empty, addr_fifo_rd, vctr_fifo_wr, vctr_fifo_rd;

  always #5 clk = ~clk;

  driver_mc #(.NUM_CH(NCH), .ADDR_DEPTH(DEPTH), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .slave_addr(slave_addr), .slave_rd(slave_rd),
    .slave_wr(slave_wr), .slave_data_in(slave_data_in), .slave_data_out(slave_data_out),
    .addr_fifo_dout(addr_fifo_dout), .addr_fifo_empty(addr_fifo_empty),
    .addr_fifo_rd(addr_fifo_rd), .vctr_fifo_wr(vctr_fifo_wr), .vctr_fifo_rd(vctr_fifo_rd),
    .irq(irq)
  );

  int nchk = 0;
  int npass = 0;
  bit quiet = 0;

  // Reference model state
  int unsigned mq[NCH][$];
  int          mvl[NCH], mvt[NCH], mdc[NCH];
  logic [3:0]  movf, munf, mdrop;
  logic        m_irq;
  logic [31:0] m_rdata;

  typedef struct {
    logic wr; logic rd; logic [31:0] a; logic [31:0] d;
    logic [3:0] afr; logic [3:0] vw; logic [3:0] vr;
    logic chk; logic [31:0] exp_rd; logic exp_irq;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] caddr(input int ch, input int off);
    return 32'h100 + 32'(ch) * 32'h20 + 32'(off);
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (a == 32'h4) return {12'b0, mdrop, 4'b0, munf, 4'b0, movf};
    for (int i = 0; i < NCH; i++) begin
      if (a == caddr(i, 4))  return 32'(mq[i].size());
      if (a == caddr(i, 8))  return 32'(mvl[i]);
      if (a == caddr(i, 12)) return 32'(mvt[i]);
      if (a == caddr(i, 16)) return 32'(mdc[i]);
    end
    return 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      mq[i].delete(); mvl[i] = 0; mvt[i] = 0; mdc[i] = 0;
    end
    movf = '0; munf = '0; mdrop = '0; m_irq = 1'b0;
  endtask

  task automatic model_step(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] afr,
                            input logic [3:0] vw, input logic [3:0] vr);
    logic [3:0] so, su, sd;
    logic prev_any;
    so = '0; su = '0; sd = '0;
    prev_any = |{movf, munf, mdrop};
    if (rd) m_rdata = mread(a);
    if (wr && a == 32'h0 && d[0]) begin
      model_clear();
      return;
    end
    m_irq = prev_any;
    for (int i = 0; i < NCH; i++) begin
      if (afr[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      if (wr && a == caddr(i, 0)) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(d);
        else begin sd[i] = 1'b1; if (mdc[i] < CMAX) mdc[i]++; end
      end
      if (vw[i] && !vr[i]) begin
        if (mvl[i] == CMAX) so[i] = 1'b1; else mvl[i]++;
      end else if (vr[i] && !vw[i]) begin
        if (mvl[i] == 0) su[i] = 1'b1; else mvl[i]--;
      end
      if (vw[i] && mvt[i] < CMAX) mvt[i]++;
    end
    if (wr && a == 32'h4) begin
      movf &= ~d[3:0]; munf &= ~d[11:8]; mdrop &= ~d[19:16];
    end
    movf |= so; munf |= su; mdrop |= sd;
  endtask

  task automatic check_outputs();
    logic [3:0] e;
    if (quiet) return;
    for (int i = 0; i < NCH; i++) e[i] = (mq[i].size() == 0);
    check("empty", addr_fifo_empty, e);
    check("irq", irq, m_irq);
    check("rdata", slave_data_out, m_rdata);
    for (int i = 0; i < NCH; i++)
      if (mq[i].size() > 0) check($sformatf("dout%0d", i), addr_fifo_dout[i*DW +: DW], mq[i][0]);
  endtask

  task automatic idle_inputs();
    slave_wr = 0; slave_rd = 0; slave_addr = 0; slave_data_in = 0;
    addr_fifo_rd = 0; vctr_fifo_wr = 0; vctr_fifo_rd = 0;
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic cycle(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] afr, input logic [3:0] vw, input logic [3:0] vr);
    slave_wr = wr; slave_rd = rd; slave_addr = a; slave_data_in = d;
    addr_fifo_rd = afr; vctr_fifo_wr = vw; vctr_fifo_rd = vr;
    @(posedge clk);
    model_step(wr, rd, a, d, afr, vw, vr);
    @(negedge clk);
    idle_inputs();
    check_outputs();
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    cycle(0, 1, a, 0, 0, 0, 0);
    check(name, slave_data_out, exp);
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] afr, input logic [3:0] vw,
                              input logic [3:0] vr, input logic chk, input logic [31:0] exp_rd,
                              input logic exp_irq);
    vec_t v;
    v.wr = wr; v.rd = rd; v.a = a; v.d = d; v.afr = afr; v.vw = vw; v.vr = vr;
    v.chk = chk; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    return v;
  endfunction

  initial begin
    logic [31:0] a, d;
    logic wr, rd;
    idle_inputs();
    reset = 0;
    model_clear();
    m_rdata = 0;

    // Reset state
    #1 reset = 1;
    #1;
    check("rst_rdata", slave_data_out, 32'h0);
    check("rst_dout", addr_fifo_dout, '0);
    check("rst_empty", addr_fifo_empty, 4'hF);
    check("rst_irq", irq, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;

    // Vector table: register reads, vector counter arithmetic, unf sticky and W1C timing
    tbl.push_back(mk(0, 1, 32'h104, 0, 0, 0, 0, 1, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h108, 0, 0, 0, 0, 1, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h004, 0, 0, 0, 0, 1, 32'h0, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 4'h2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h2, 4'h2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h128, 0, 0, 0, 0, 1, 32'd3, 0));
    tbl.push_back(mk(0, 1, 32'h12C, 0, 0, 0, 0, 1, 32'd6, 0));
    tbl.push_back(mk(0, 1, 32'h13C, 0, 0, 0, 0, 1, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h200, 0, 0, 0, 0, 1, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h4, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h004, 0, 0, 0, 0, 1, 32'h400, 1));
    tbl.push_back(mk(0, 1, 32'h148, 0, 0, 0, 0, 1, 32'h0, 1));
    tbl.push_back(mk(1, 0, 32'h004, 32'h400, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h004, 0, 0, 0, 0, 1, 32'h0, 0));
    foreach (tbl[k]) begin
      cycle(tbl[k].wr, tbl[k].rd, tbl[k].a, tbl[k].d, tbl[k].afr, tbl[k].vw, tbl[k].vr);
      if (tbl[k].chk) check($sformatf("tbl%0d_rd", k), slave_data_out, tbl[k].exp_rd);
      check($sformatf("tbl%0d_irq", k), irq, tbl[k].exp_irq);
    end

    // Overfill ch0, then drain in order
    for (int k = 0; k < 18; k++) cycle(1, 0, 32'h100, 32'h1000 + 32'(k), 0, 0, 0);
    rd_chk("ch0_level", 32'h104, 32'd16);
    rd_chk("ch0_drop", 32'h110, 32'd2);
    rd_chk("status_drop0", 32'h004, 32'h10000);
    check("irq_drop", irq, 1'b1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("pop%0d", k), addr_fifo_dout[31:0], 32'h1000 + 32'(k));
      cycle(0, 0, 0, 0, 4'h1, 0, 0);
    end
    check("ch0_drained", addr_fifo_empty[0], 1'b1);
    cycle(1, 0, 32'h004, 32'h10000, 0, 0, 0);

    // Full ch3: push+pop together, then push while only ch0 pops
    for (int k = 0; k < 16; k++) cycle(1, 0, 32'h160, 32'h3000 + 32'(k), 0, 0, 0);
    cycle(1, 0, 32'h160, 32'h3AAA, 4'h8, 0, 0);
    rd_chk("ch3_level", 32'h164, 32'd16);
    rd_chk("ch3_drop0", 32'h170, 32'd0);
    check("ch3_head", addr_fifo_dout[3*DW +: DW], 32'h3001);
    cycle(1, 0, 32'h100, 32'h55, 0, 0, 0);
    cycle(1, 0, 32'h160, 32'h3BBB, 4'h1, 0, 0);
    rd_chk("ch3_drop1", 32'h170, 32'd1);
    rd_chk("ch3_level2", 32'h164, 32'd16);
    rd_chk("ch0_level0", 32'h104, 32'd0);

    // Saturate ch2 vector counters
    quiet = 1;
    repeat (65536) cycle(0, 0, 0, 0, 0, 4'h4, 0);
    quiet = 0;
    cycle(0, 0, 0, 0, 0, 4'h4, 0);
    rd_chk("ch2_vlvl_max", 32'h148, 32'hFFFF);
    rd_chk("ch2_vtot_max", 32'h14C, 32'hFFFF);
    cycle(0, 1, 32'h004, 0, 0, 0, 0);
    check("status_ovf2", slave_data_out[2], 1'b1);
    cycle(1, 0, 32'h004, 32'hF0F0F, 0, 0, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      d = $urandom;
      wr = ($urandom_range(0, 2) == 0);
      rd = $urandom_range(0, 1);
      case (sel)
        0, 1, 2, 3: a = caddr(sel, 0);
        4: a = 32'h004;
        5: a = caddr(int'($urandom_range(0, 3)), 4 * int'($urandom_range(1, 4)));
        6: a = ($urandom_range(0, 1) == 1) ? 32'h300 : 32'h11C;
        default: begin
          a = 32'h000;
          if ($urandom_range(0, 7) != 0) d[0] = 1'b0;
        end
      endcase
      cycle(wr, rd, a, d, 4'($urandom), 4'($urandom), 4'($urandom));
    end

    // Soft clear in the middle of traffic
    cycle(1, 0, 32'h100, 32'h11, 0, 4'h2, 0);
    cycle(1, 0, 32'h100, 32'h22, 0, 4'h2, 0);
    cycle(1, 0, 32'h000, 32'h1, 4'h0, 4'hF, 4'h0);
    check("sc_empty", addr_fifo_empty, 4'hF);
    check("sc_irq", irq, 1'b0);
    rd_chk("sc_alvl", 32'h104, 32'h0);
    rd_chk("sc_vlvl", 32'h128, 32'h0);
    rd_chk("sc_vtot", 32'h12C, 32'h0);
    rd_chk("sc_status", 32'h004, 32'h0);

    // Asynchronous reset mid-traffic with strobes held through the reset edges
    cycle(1, 0, 32'h100, 32'h77, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 4'h1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("pre_rst_irq", irq, 1'b1);
    slave_wr = 1; slave_addr = 32'h100; slave_data_in = 32'h99; vctr_fifo_wr = 4'hF;
    #2 reset = 1;
    #1;
    check("arst_empty", addr_fifo_empty, 4'hF);
    check("arst_irq", irq, 1'b0);
    check("arst_dout", addr_fifo_dout, '0);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    reset = 0;
    model_clear();
    m_rdata = 0;
    check("arst_rdata", slave_data_out, 32'h0);
    rd_chk("arst_vtot", 32'h12C, 32'h0);
    cycle(1, 0, 32'h100, 32'hABCD, 0, 0, 0);
    check("abcd_dout", addr_fifo_dout[31:0], 32'hABCD);
    check("abcd_empty", addr_fifo_empty, 4'hE);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
